// File: rtl/dispatch_pkg.sv
// dispatch_pkg: shared definitions for the dispatch queue.
//   DQ_BUNDLE_W       width of one decoded ID/EX bundle
//   DQ_*_OFF / DQ_*_W bit offset and width of each bundle field
//   dq_bundle_t       packed view of a bundle; pc occupies the MSBs
package dispatch_pkg;

  localparam int DQ_PC_W         = 32;
  localparam int DQ_OPCODE_W     = 7;
  localparam int DQ_FUNCT3_W     = 3;
  localparam int DQ_FUNCT7_W     = 7;
  localparam int DQ_REG_W        = 5;
  localparam int DQ_IMM_W        = 32;
  localparam int DQ_STORE_SIZE_W = 2;

  localparam int DQ_STORE_SIZE_OFF = 0;
  localparam int DQ_HAS_IMM_OFF    = 2;
  localparam int DQ_MEM_TO_REG_OFF = 3;
  localparam int DQ_MEM_WRITE_OFF  = 4;
  localparam int DQ_MEM_READ_OFF   = 5;
  localparam int DQ_REG_WRITE_OFF  = 6;
  localparam int DQ_LW_SW_OFF      = 7;
  localparam int DQ_IMM_OFF        = 8;
  localparam int DQ_DEST_REG_OFF   = DQ_IMM_OFF + DQ_IMM_W;          // 40
  localparam int DQ_SRC_REG2_OFF   = DQ_DEST_REG_OFF + DQ_REG_W;     // 45
  localparam int DQ_SRC_REG1_OFF   = DQ_SRC_REG2_OFF + DQ_REG_W;     // 50
  localparam int DQ_FUNCT7_OFF     = DQ_SRC_REG1_OFF + DQ_REG_W;     // 55
  localparam int DQ_FUNCT3_OFF     = DQ_FUNCT7_OFF + DQ_FUNCT7_W;    // 62
  localparam int DQ_OPCODE_OFF     = DQ_FUNCT3_OFF + DQ_FUNCT3_W;    // 65
  localparam int DQ_PC_OFF         = DQ_OPCODE_OFF + DQ_OPCODE_W;    // 72

  localparam int DQ_BUNDLE_W = DQ_PC_OFF + DQ_PC_W;                  // 104

  typedef struct packed {
    logic [DQ_PC_W-1:0]         pc;
    logic [DQ_OPCODE_W-1:0]     opcode;
    logic [DQ_FUNCT3_W-1:0]     funct3;
    logic [DQ_FUNCT7_W-1:0]     funct7;
    logic [DQ_REG_W-1:0]        src_reg1;
    logic [DQ_REG_W-1:0]        src_reg2;
    logic [DQ_REG_W-1:0]        dest_reg;
    logic [DQ_IMM_W-1:0]        imm;
    logic                       lw_sw;
    logic                       reg_write;
    logic                       mem_read;
    logic                       mem_write;
    logic                       mem_to_reg;
    logic                       has_imm;
    logic [DQ_STORE_SIZE_W-1:0] store_size;
  } dq_bundle_t;

endpackage

// File: rtl/dispatch_queue_storage.sv
// dq_storage_ram: DEPTH x BW entry array for the dispatch queue.
//   clk, rstn      clock, async active-low reset (clears every entry)
//   we/waddr/wdata single write port, written on the rising edge
//   raddr/rdata    asynchronous read port
module dq_storage_ram #(
  parameter int DEPTH = 4,
  parameter int BW    = 104,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [BW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [BW-1:0] rdata
);

  logic [BW-1:0] mem_q [DEPTH];
  logic [BW-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/dispatch_queue.sv
// dispatch_queue: FIFO of decoded instruction bundles between ID/EX and issue.
//   clk, rstn                   clock, async active-low reset
//   in_valid/in_bundle/in_ready push side (in_ready never depends on out_ready)
//   out_valid/out_bundle/out_ready pop side, head of queue
//   flush                       synchronous discard of all entries, wins over push/pop
//   count                       current occupancy
// Optional feature: define DISPATCH_QUEUE_BYPASS_EN to let an empty queue pass
// a bundle straight through in the same cycle; otherwise latency is fixed at 1.
module dispatch_queue
  import dispatch_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int BW    = DQ_BUNDLE_W
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     in_valid,
  input  logic [BW-1:0]            in_bundle,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [BW-1:0]            out_bundle,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Held low through reset so in_ready rises only at the first edge after release.
  logic             ready_en_q, ready_en_d;

  logic             empty, full, push, pop, wr_en;
  logic [BW-1:0]    head;

  dq_storage_ram #(
    .DEPTH (DEPTH),
    .BW    (BW),
    .AW    (PTR_W)
  ) u_storage (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (in_bundle),
    .raddr (rd_ptr_q),
    .rdata (head)
  );

  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == FULL_CNT);
    in_ready = ready_en_q && !full;
    push     = in_valid && in_ready;
    pop      = !empty && out_ready;
    wr_en    = push && !flush;
`ifdef DISPATCH_QUEUE_BYPASS_EN
    // Empty queue: present the incoming bundle directly; if it is taken
    // this cycle it never lands in storage.
    if (empty && !flush && ready_en_q) begin
      out_valid  = in_valid;
      out_bundle = in_bundle;
      if (out_ready) wr_en = 1'b0;
    end else begin
      out_valid  = !empty;
      out_bundle = head;
    end
`else
    out_valid  = !empty;
    out_bundle = head;
`endif
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ready_en_d = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap for free since DEPTH is a power of two.
      if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      ready_en_q <= ready_en_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_dispatch_queue.sv
module tb_dispatch_queue;
  import dispatch_pkg::*;

  localparam int DEPTH = 4;
  localparam int BW    = DQ_BUNDLE_W;

  logic                  clk;
  logic                  rstn;
  logic                  in_valid;
  logic [BW-1:0]         in_bundle;
  logic                  in_ready;
  logic                  out_valid;
  logic [BW-1:0]         out_bundle;
  logic                  out_ready;
  logic                  flush;
  logic [$clog2(DEPTH):0] count;

  int total = 0;
  int bad   = 0;

  logic [BW-1:0] mq [$];
  logic          rdy_m;

  dispatch_queue #(.DEPTH(DEPTH), .BW(BW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_bundle  (in_bundle),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_bundle (out_bundle),
    .out_ready  (out_ready),
    .flush      (flush),
    .count      (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_model();
    chk("count", 128'(count), 128'(mq.size()));
    chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    chk("in_ready", 128'(in_ready), 128'(rdy_m && (mq.size() < DEPTH)));
    if (mq.size() != 0) chk("out_bundle", 128'(out_bundle), 128'(mq[0]));
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic step(input logic iv, input logic [BW-1:0] b, input logic ordy, input logic fl);
    logic pu, po;
    in_valid  = iv;
    in_bundle = b;
    out_ready = ordy;
    flush     = fl;
    pu = iv && rdy_m && (mq.size() < DEPTH);
    po = (mq.size() != 0) && ordy;
`ifdef DISPATCH_QUEUE_BYPASS_EN
    if (mq.size() == 0 && !fl && rdy_m && iv && ordy) pu = 1'b0;
`endif
    @(posedge clk);
    if (fl) mq.delete();
    else begin
      if (po) void'(mq.pop_front());
      if (pu) mq.push_back(b);
    end
    rdy_m = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
    check_model();
  endtask

  function automatic logic [BW-1:0] mk(input logic [31:0] pc, input logic [6:0] op);
    dq_bundle_t s;
    s        = '0;
    s.pc     = pc;
    s.opcode = op;
    s.imm    = ~pc;
    return s;
  endfunction

  function automatic logic [BW-1:0] rnd_bundle();
    logic [127:0] r;
    r = {$urandom(), $urandom(), $urandom(), $urandom()};
    return r[BW-1:0];
  endfunction

  initial begin
    logic [BW-1:0] b;
    logic [BW-1:0] xb;
    dq_bundle_t    hd;
    rstn = 1'b0; in_valid = 1'b0; in_bundle = '0; out_ready = 1'b0; flush = 1'b0;
    rdy_m = 1'b0;

    // reset values
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_out_bundle", 128'(out_bundle), 128'(0));
    rstn = 1'b1;
    #1 chk("rel_in_ready_pre_edge", 128'(in_ready), 128'(0));
    step(1'b0, '0, 1'b0, 1'b0);
    chk("rel_in_ready_post_edge", 128'(in_ready), 128'(1));

    // single push, latency 1
    step(1'b1, mk(32'h100, 7'h33), 1'b0, 1'b0);
    hd = out_bundle;
    chk("first_valid", 128'(out_valid), 128'(1));
    chk("first_pc", 128'(hd.pc), 128'(32'h100));
    chk("first_opcode", 128'(hd.opcode), 128'(7'h33));
    chk("first_count", 128'(count), 128'(1));

    // fill, overflow refused, drain in order
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, mk(32'(4 * i), 7'h13), 1'b0, 1'b0);
    chk("full_count", 128'(count), 128'(4));
    chk("full_in_ready", 128'(in_ready), 128'(0));
    step(1'b1, mk(32'h55, 7'h13), 1'b1, 1'b0);
    chk("full_pop_no_push_count", 128'(count), 128'(3));
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, mk(32'(4 * i), 7'h13), 1'b0, 1'b0);
    step(1'b1, mk(32'h99, 7'h13), 1'b0, 1'b0);
    chk("fifth_ignored_count", 128'(count), 128'(4));
    for (int i = 0; i < 4; i++) begin
      hd = out_bundle;
      chk("drain_pc", 128'(hd.pc), 128'(4 * i));
      step(1'b0, '0, 1'b1, 1'b0);
    end
    chk("drained_valid", 128'(out_valid), 128'(0));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("empty_no_pop_count", 128'(count), 128'(0));

    // steady push+pop at count=2, pointers wrap
    step(1'b1, mk(32'h200, 7'h03), 1'b0, 1'b0);
    step(1'b1, mk(32'h204, 7'h03), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      hd = out_bundle;
      chk("pp_head_pc", 128'(hd.pc), 128'(32'h200 + 4 * i));
      step(1'b1, mk(32'h208 + 32'(4 * i), 7'h03), 1'b1, 1'b0);
      chk("pp_count", 128'(count), 128'(2));
    end

    // flush wins over same-cycle push
    step(1'b1, mk(32'h300, 7'h23), 1'b0, 1'b0);
    chk("pre_flush_count", 128'(count), 128'(3));
    step(1'b1, mk(32'h304, 7'h23), 1'b1, 1'b1);
    chk("flush_count", 128'(count), 128'(0));
    chk("flush_valid", 128'(out_valid), 128'(0));

    // randomized traffic against the queue model
    for (int ph = 0; ph < 3; ph++) begin
      int piv, pord;
      piv  = (ph == 0) ? 80 : (ph == 1) ? 30 : 55;
      pord = (ph == 0) ? 30 : (ph == 1) ? 80 : 55;
      for (int n = 0; n < 600; n++) begin
        b = rnd_bundle();
        step($urandom_range(99) < piv, b, $urandom_range(99) < pord,
             $urandom_range(63) == 0);
      end
    end

    // async reset mid-stream
    step(1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b1, rnd_bundle(), 1'b0, 1'b0);
    chk("pre_rst_count", 128'(count), 128'(3));
    #2 rstn = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    chk("arst_out_bundle", 128'(out_bundle), 128'(0));
    chk("arst_count", 128'(count), 128'(0));
    mq.delete();
    rdy_m = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, mk(32'h400, 7'h33), 1'b0, 1'b0);

`ifdef DISPATCH_QUEUE_BYPASS_EN
    step(1'b0, '0, 1'b1, 1'b0);
    xb = mk(32'h500, 7'h67);
    in_valid = 1'b1; in_bundle = xb; out_ready = 1'b1;
    #1;
    chk("byp_out_valid", 128'(out_valid), 128'(1));
    chk("byp_out_bundle", 128'(out_bundle), 128'(xb));
    step(1'b1, xb, 1'b1, 1'b0);
    chk("byp_count", 128'(count), 128'(0));
    step(1'b1, xb, 1'b0, 1'b0);
    chk("byp_stall_count", 128'(count), 128'(1));
`else
    xb = '0;
    in_bundle = xb;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
